// File: rtl/fas32_bist.sv
// Built-in self-test driver/checker for a 32-bit full adder/subtractor.
// Optional FAS_BIST_STOP_ON_FAIL_EN: stop on first mismatch and expose capture ports.
module fas32_bist #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'h25CA25CA,
    parameter int unsigned SETTLE      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic        bcin_out,
    input  logic [31:0] sum_in,
    input  logic [31:0] diff_in,
    input  logic        cout_in,
    input  logic        bout_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_count,
    output logic [15:0] err_vec_idx
`ifdef FAS_BIST_STOP_ON_FAIL_EN
    ,
    output logic [31:0] cap_sum,
    output logic [31:0] cap_diff,
    output logic        cap_cout,
    output logic        cap_bout
`endif
);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, FIN} state_t;

    localparam logic [3:0]  SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : '0);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] vec_idx_q, vec_idx_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        bcin_q, bcin_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0] fail_q, fail_d, err_q, err_d;
    logic [31:0] lfsr_s1, lfsr_s2;
    logic [32:0] exp_sum33, exp_diff33;
    logic        mismatch;
`ifdef FAS_BIST_STOP_ON_FAIL_EN
    logic [31:0] cap_sum_q, cap_sum_d, cap_diff_q, cap_diff_d;
    logic        cap_cout_q, cap_cout_d, cap_bout_q, cap_bout_d;
`endif

    always_comb begin
        state_d    = state_q;
        vec_idx_d  = vec_idx_q;
        wait_cnt_d = wait_cnt_q;
        lfsr_d     = lfsr_q;
        a_d        = a_q;
        b_d        = b_q;
        bcin_d     = bcin_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        err_d      = err_q;
`ifdef FAS_BIST_STOP_ON_FAIL_EN
        cap_sum_d  = cap_sum_q;
        cap_diff_d = cap_diff_q;
        cap_cout_d = cap_cout_q;
        cap_bout_d = cap_bout_q;
`endif
        // Both LFSR steps for one random vector happen in the same APPLY cycle
        lfsr_s1    = lfsr_step(lfsr_q);
        lfsr_s2    = lfsr_step(lfsr_s1);
        exp_sum33  = {1'b0, a_q} + {1'b0, b_q} + 33'(bcin_q);
        exp_diff33 = {1'b0, a_q} - {1'b0, b_q} - 33'(bcin_q);
        mismatch   = {sum_in, diff_in, cout_in, bout_in} !=
                     {exp_sum33[31:0], exp_diff33[31:0], exp_sum33[32], exp_diff33[32]};

        case (state_q)
            IDLE, FIN: begin
                if (state_q == FIN) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (fail_q == '0);
                end
                if (start) begin
                    state_d   = APPLY;
                    vec_idx_d = '0;
                    fail_d    = '0;
                    err_d     = '1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    lfsr_d    = SEED;
                end
            end
            APPLY: begin
                case (vec_idx_q)
                    16'd0: begin a_d = '0;           b_d = '0;           bcin_d = 1'b0; end
                    16'd1: begin a_d = '1;           b_d = 32'h00000001; bcin_d = 1'b0; end
                    16'd2: begin a_d = '1;           b_d = '1;           bcin_d = 1'b1; end
                    16'd3: begin a_d = '0;           b_d = 32'h00000001; bcin_d = 1'b1; end
                    default: begin
                        a_d    = lfsr_s1;
                        b_d    = lfsr_s2;
                        bcin_d = vec_idx_q[0];
                        lfsr_d = lfsr_s2;
                    end
                endcase
                wait_cnt_d = '0;
                state_d    = (SETTLE > 0) ? WAIT : CHECK;
            end
            WAIT: begin
                if (wait_cnt_q == SETTLE_LAST) state_d = CHECK;
                else                           wait_cnt_d = wait_cnt_q + 4'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    if (fail_q != '1) fail_d = fail_q + 16'd1;
                    if (err_q == '1)  err_d  = vec_idx_q;
                end
`ifdef FAS_BIST_STOP_ON_FAIL_EN
                if (mismatch) begin
                    cap_sum_d  = sum_in;
                    cap_diff_d = diff_in;
                    cap_cout_d = cout_in;
                    cap_bout_d = bout_in;
                    state_d    = FIN;
                end else if (vec_idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    vec_idx_d = vec_idx_q + 16'd1;
                    state_d   = APPLY;
                end
`else
                if (vec_idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    vec_idx_d = vec_idx_q + 16'd1;
                    state_d   = APPLY;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_idx_q  <= '0;
            wait_cnt_q <= '0;
            lfsr_q     <= SEED;
            a_q        <= '0;
            b_q        <= '0;
            bcin_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= '0;
            err_q      <= '1;
`ifdef FAS_BIST_STOP_ON_FAIL_EN
            cap_sum_q  <= '0;
            cap_diff_q <= '0;
            cap_cout_q <= 1'b0;
            cap_bout_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            vec_idx_q  <= vec_idx_d;
            wait_cnt_q <= wait_cnt_d;
            lfsr_q     <= lfsr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            bcin_q     <= bcin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
`ifdef FAS_BIST_STOP_ON_FAIL_EN
            cap_sum_q  <= cap_sum_d;
            cap_diff_q <= cap_diff_d;
            cap_cout_q <= cap_cout_d;
            cap_bout_q <= cap_bout_d;
`endif
        end
    end

    assign a_out       = a_q;
    assign b_out       = b_q;
    assign bcin_out    = bcin_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_count  = fail_q;
    assign err_vec_idx = err_q;
`ifdef FAS_BIST_STOP_ON_FAIL_EN
    assign cap_sum  = cap_sum_q;
    assign cap_diff = cap_diff_q;
    assign cap_cout = cap_cout_q;
    assign cap_bout = cap_bout_q;
`endif

endmodule

// File: tb/tb_fas32_bist.sv
// Directed bench for fas32_bist with a behavioural adder/subtractor that can carry planted faults.
module tb_fas32_bist;

    logic        clk, rst, start;
    logic [31:0] a_out, b_out, sum_in, diff_in;
    logic        bcin_out, cout_in, bout_in;
    logic        busy, done, pass;
    logic [15:0] fail_count, err_vec_idx;
`ifdef FAS_BIST_STOP_ON_FAIL_EN
    logic [31:0] cap_sum, cap_diff;
    logic        cap_cout, cap_bout;
`endif

    logic [1:0]  fault;  // 0 none, 1 sum[0] stuck at 0, 2 bout inverted
    logic [32:0] s33, d33;
    int          errors = 0;
    int          checks = 0;
    int          dn;

    localparam logic [31:0] SEED = 32'h25CA25CA;

    fas32_bist #(.NUM_VECTORS(256), .SEED(SEED), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a_out), .b_out(b_out), .bcin_out(bcin_out),
        .sum_in(sum_in), .diff_in(diff_in), .cout_in(cout_in), .bout_in(bout_in),
        .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .err_vec_idx(err_vec_idx)
`ifdef FAS_BIST_STOP_ON_FAIL_EN
        , .cap_sum(cap_sum), .cap_diff(cap_diff), .cap_cout(cap_cout), .cap_bout(cap_bout)
`endif
    );

    always_comb begin
        s33     = {1'b0, a_out} + {1'b0, b_out} + 33'(bcin_out);
        d33     = {1'b0, a_out} - {1'b0, b_out} - 33'(bcin_out);
        sum_in  = s33[31:0] & ~{31'd0, fault == 2'd1};
        cout_in = s33[32];
        diff_in = d33[31:0];
        bout_in = d33[32] ^ (fault == 2'd2);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a"}, a_out, 32'h0);
        chk({tag, "_b"}, b_out, 32'h0);
        chk({tag, "_bcin"}, 32'(bcin_out), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pass"}, 32'(pass), 32'h0);
        chk({tag, "_fail"}, 32'(fail_count), 32'h0);
        chk({tag, "_err"}, 32'(err_vec_idx), 32'h0000FFFF);
    endtask

    // Pulses start, then steps until done (dn = cycles after the start edge), a reset (dn=-2) or timeout (dn=-1).
    task automatic do_run(input int rst_at, input int restart_at, output int done_n);
        logic [31:0] s1, s2;
        logic        busy_ok;
        s1 = lfsr_step(SEED);
        s2 = lfsr_step(s1);
        busy_ok = 1'b1;
        done_n  = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'h1);
        chk("done_after_start", 32'(done), 32'h0);
        for (int n = 1; n <= 2000; n++) begin
            if (n == restart_at) start = 1'b1;
            if (n == rst_at) rst = 1'b1;
            tick();
            start = 1'b0;
            if (n == rst_at) begin
                chk_reset("midrun_rst");
                rst = 1'b0;
                done_n = -2;
                return;
            end
            if (fault == 2'd0 && n == 4) begin
                chk("idx1_a", a_out, 32'hFFFFFFFF);
                chk("idx1_b", b_out, 32'h00000001);
            end
            if (fault == 2'd0 && n == 13) begin
                chk("idx4_a", a_out, s1);
                chk("idx4_b", b_out, s2);
                chk("idx4_bcin", 32'(bcin_out), 32'h0);
            end
            if (done) begin
                done_n = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        chk("busy_held_until_done", 32'(busy_ok), 32'h1);
        chk("busy_low_at_done", 32'(busy), 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fault = 2'd0;
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        chk("idle_done", 32'(done), 32'h0);

        // Clean run with a stray start at cycle 100
        do_run(0, 100, dn);
        chk("clean_done_cycle", 32'(dn), 32'd769);
        chk("clean_pass", 32'(pass), 32'h1);
        chk("clean_fail", 32'(fail_count), 32'h0);
        chk("clean_err", 32'(err_vec_idx), 32'h0000FFFF);
        repeat (3) tick();
        chk("fin_done_held", 32'(done), 32'h1);

        // Rerun from FIN must reproduce the same operand sequence
        do_run(0, 0, dn);
        chk("rerun_done_cycle", 32'(dn), 32'd769);
        chk("rerun_pass", 32'(pass), 32'h1);

        fault = 2'd1;
        do_run(0, 0, dn);
`ifdef FAS_BIST_STOP_ON_FAIL_EN
        chk("stuck_done_cycle", 32'(dn), 32'd10);
        chk("stuck_fail", 32'(fail_count), 32'd1);
        chk("stuck_cap_sum", cap_sum, 32'hFFFFFFFE);
        chk("stuck_cap_diff", cap_diff, 32'hFFFFFFFF);
        chk("stuck_cap_cout", 32'(cap_cout), 32'h1);
        chk("stuck_cap_bout", 32'(cap_bout), 32'h1);
        chk("stuck_a", a_out, 32'hFFFFFFFF);
        chk("stuck_b", b_out, 32'hFFFFFFFF);
        chk("stuck_bcin", 32'(bcin_out), 32'h1);
`else
        chk("stuck_done_cycle", 32'(dn), 32'd769);
        chk("stuck_fail_nonzero", 32'(fail_count >= 16'd1), 32'h1);
`endif
        chk("stuck_err", 32'(err_vec_idx), 32'd2);
        chk("stuck_pass", 32'(pass), 32'h0);

        fault = 2'd2;
        do_run(0, 0, dn);
`ifdef FAS_BIST_STOP_ON_FAIL_EN
        chk("bout_done_cycle", 32'(dn), 32'd4);
        chk("bout_fail", 32'(fail_count), 32'd1);
`else
        chk("bout_done_cycle", 32'(dn), 32'd769);
        chk("bout_fail", 32'(fail_count), 32'd256);
`endif
        chk("bout_err", 32'(err_vec_idx), 32'd0);
        chk("bout_pass", 32'(pass), 32'h0);

        fault = 2'd0;
        do_run(300, 0, dn);
        chk("rst_run_aborted", 32'(dn), 32'hFFFFFFFE);
        tick();
        chk("after_rst_busy", 32'(busy), 32'h0);
        do_run(0, 0, dn);
        chk("post_rst_done_cycle", 32'(dn), 32'd769);
        chk("post_rst_pass", 32'(pass), 32'h1);
        chk("post_rst_err", 32'(err_vec_idx), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
